decoder_arbiter_4: RTL and testbench

Round-robin arbiter that shares the 2-to-4 decoder between four requesters. It drives the decoder's `enable`, `a` and `b` select inputs so that exactly one requester's decoder output line is active at a time. It also provides the equivalent one-hot grant vector directly. It sits between the requesting blocks and the `Decoder_2to4` instance, and is the only driver of the decoder inputs.

---
 rtl/decoder_arbiter_4.sv | 160 ++++++++++++++++
 tb/tb_decoder_arbiter_4.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_arbiter_4.sv
// decoder_arbiter_4: round-robin arbiter sharing a 2-to-4 decoder between
// four requesters. Drives the decoder enable/select lines and an equivalent
// one-hot grant. Every output comes straight from a register.
// Optional feature macro: DECODER_ARB_TIMEOUT_EN (hold-time preemption).
module decoder_arbiter_4 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic       enable,
    output logic       a,
    output logic       b,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       any_req;
    logic       force_rel;
    logic       en_q, en_d;
    logic       busy_q, busy_d;
    logic       pre_q, pre_d;
    logic [3:0] gnt_q, gnt_d;

    // Out-of-range HOLD_MAX leaves a marker block in the elaborated hierarchy.
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_out_of_range
    end

    assign any_req = |req;

    // Winner search: first set request scanning upward from ptr, wrapping.
    always_comb begin
        win   = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

`ifdef DECODER_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] cnt_q, cnt_d;

    // Saturating >= keeps a late competitor from waiting forever once the
    // owner has already passed the limit with nobody else asking.
    always_comb begin
        force_rel = (state_q == GRANT) && (cnt_q >= HOLD_LAST) &&
                    ((req & ~gnt_q) != '0);
    end

    // Hold counter: clears on entry to GRANT, counts GRANT cycles, saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == GRANT) begin
            if (state_q != GRANT) begin
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    // Next-state, owner/pointer update and next registered outputs.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        pre_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    owner_d = win;
                    ptr_d   = win + 2'd1;
                end
            end
            GRANT: begin
                if (!req[owner_q] || force_rel) begin
                    state_d = GAP;
                    pre_d   = force_rel;
                end
            end
            GAP: begin
                if (any_req) begin
                    state_d = GRANT;
                    owner_d = win;
                    ptr_d   = win + 2'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        en_d   = (state_d == GRANT);
        busy_d = (state_d != IDLE);
        gnt_d  = en_d ? (4'b0001 << owner_d) : 4'b0000;
    end

    // State and output registers; outputs are decoded ahead so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            pre_q   <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            pre_q   <= pre_d;
            gnt_q   <= gnt_d;
        end
    end

    assign enable  = en_q;
    assign a       = owner_q[0];
    assign b       = owner_q[1];
    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign preempt = pre_q;

endmodule

// File: tb/tb_decoder_arbiter_4.sv
// Directed bench for decoder_arbiter_4 with hand-computed expectations.
// Timeout section is active only when DECODER_ARB_TIMEOUT_EN is defined.
module tb_decoder_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       enable;
    logic       a;
    logic       b;
    logic [3:0] gnt;
    logic       busy;
    logic       preempt;

    int unsigned total;
    int unsigned passed;
    int unsigned fails;

    decoder_arbiter_4 #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .enable  (enable),
        .a       (a),
        .b       (b),
        .gnt     (gnt),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic bz, input logic en,
                              input logic [1:0] ow, input logic [3:0] g,
                              input logic pre);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {busy, enable, b, a, gnt, preempt};
        exp = {bz, en, ow, g, pre};
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed {busy,en,b,a,gnt,pre}=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] ow;
        total  = 0;
        passed = 0;
        fails  = 0;
        rst_n  = 1'b0;
        req    = 4'b0000;
        #2;
        expect_out("reset_async", 0, 0, 2'd0, 4'b0000, 0);
        step();
        expect_out("reset_held", 0, 0, 2'd0, 4'b0000, 0);
        rst_n = 1'b1;

        // Single request on line 2, then release.
        req = 4'b0100;
        step();
        expect_out("single_grant", 1, 1, 2'd2, 4'b0100, 0);
        req = 4'b0000;
        step();
        expect_out("single_gap", 1, 0, 2'd2, 4'b0000, 0);
        step();
        expect_out("single_idle_hold_ab", 0, 0, 2'd2, 4'b0000, 0);
        step();
        expect_out("single_idle_stay", 0, 0, 2'd2, 4'b0000, 0);

        // All four requesting: rotation 0,1,2,3,0 with one GAP between grants.
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            ow = 2'(k);
            expect_out($sformatf("rr_grant%0d_c1", k), 1, 1, ow, 4'b0001 << ow, 0);
            step();
            expect_out($sformatf("rr_grant%0d_c2", k), 1, 1, ow, 4'b0001 << ow, 0);
            step();
            expect_out($sformatf("rr_grant%0d_c3", k), 1, 1, ow, 4'b0001 << ow, 0);
            if (k < 4) begin
                req = 4'b1111 & ~(4'b0001 << ow);
                step();
                expect_out($sformatf("rr_gap%0d", k), 1, 0, ow, 4'b0000, 0);
                req = 4'b1111;
                step();
            end
        end
        req = 4'b0000;
        step();
        expect_out("rr_last_gap", 1, 0, 2'd0, 4'b0000, 0);
        step();
        expect_out("rr_idle", 0, 0, 2'd0, 4'b0000, 0);

        // 1001: owner 0 then 3; req[0] returning mid-grant waits for release.
        do_reset();
        req = 4'b1001;
        step();
        expect_out("p3_owner0", 1, 1, 2'd0, 4'b0001, 0);
        req = 4'b1000;
        step();
        expect_out("p3_gap0", 1, 0, 2'd0, 4'b0000, 0);
        step();
        expect_out("p3_owner3", 1, 1, 2'd3, 4'b1000, 0);
        req = 4'b1001;
        step();
        expect_out("p3_owner3_hold_a", 1, 1, 2'd3, 4'b1000, 0);
        step();
        expect_out("p3_owner3_hold_b", 1, 1, 2'd3, 4'b1000, 0);
        req = 4'b0001;
        step();
        expect_out("p3_gap3", 1, 0, 2'd3, 4'b0000, 0);
        step();
        expect_out("p3_owner0_again", 1, 1, 2'd0, 4'b0001, 0);
        req = 4'b0000;
        step();
        step();
        expect_out("p3_idle", 0, 0, 2'd0, 4'b0000, 0);

`ifdef DECODER_ARB_TIMEOUT_EN
        // Owner 1 preempted after 4 GRANT cycles while line 2 waits.
        do_reset();
        req = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            step();
            expect_out($sformatf("to_hold_c%0d", k), 1, 1, 2'd1, 4'b0010, 0);
        end
        step();
        expect_out("to_preempt_gap", 1, 0, 2'd1, 4'b0000, 1);
        step();
        expect_out("to_owner2", 1, 1, 2'd2, 4'b0100, 0);

        // No competitor: owner 1 keeps the grant well past HOLD_MAX.
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 22; k++) begin
            step();
            expect_out($sformatf("to_nocomp_c%0d", k), 1, 1, 2'd1, 4'b0010, 0);
        end
`endif

        // Asynchronous reset between edges while owner 2 holds the grant.
        do_reset();
        req = 4'b0100;
        step();
        expect_out("ar_owner2", 1, 1, 2'd2, 4'b0100, 0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("ar_cleared", 0, 0, 2'd0, 4'b0000, 0);
        #2;
        rst_n = 1'b1;
        req   = 4'b1111;
        step();
        expect_out("ar_ptr_restart", 1, 1, 2'd0, 4'b0001, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
